// File: rtl/router_pkg.sv
`default_nettype none
// ==== router_pkg : shared types/constants for the 1x3 router input controller (rev 1.0) ====
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;

  // Header address that names no destination; such packets are dropped.
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/router_fsm_ctrl_sva.sv
`default_nettype none
// ==== router_fsm_ctrl_sva : strobe-exclusivity checker bound into router_fsm_ctrl (rev 1.0) ====
module router_fsm_ctrl_sva (
  input logic clock,
  input logic reset,
  input logic detect_add,
  input logic lfd_state,
  input logic ld_state,
  input logic laf_state,
  input logic full_state,
  input logic busy
);

  logic [4:0] w_strobes;
  assign w_strobes = {detect_add, lfd_state, ld_state, laf_state, full_state};

  a_strobe_onehot0: assert property (@(posedge clock) disable iff (reset)
    $onehot0(w_strobes));

  // Only the wait/parity states run with no strobe, and all of them are busy.
  a_no_strobe_busy: assert property (@(posedge clock) disable iff (reset)
    (w_strobes == 5'b0) |-> busy);

endmodule

bind router_fsm_ctrl router_fsm_ctrl_sva u_sva (
  .clock      (clock),
  .reset      (reset),
  .detect_add (detect_add),
  .lfd_state  (lfd_state),
  .ld_state   (ld_state),
  .laf_state  (laf_state),
  .full_state (full_state),
  .busy       (busy)
);
`default_nettype wire

// File: rtl/router_fsm_ctrl.sv
`default_nettype none
// ==== router_fsm_ctrl : input-side packet sequencing FSM for the 1x3 router (rev 1.0) ====
module router_fsm_ctrl
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_vld,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic [ADDR_W-1:0]    dest_sel,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 busy
);

  localparam int SEL_N = 1 << ADDR_W;
  localparam int PAD_W = SEL_N - NUM_PORTS;

  // Pad flag vectors to the full address range so any index is defined.
  logic [SEL_N-1:0] w_full_ext, w_empty_ext, w_srst_ext;
  assign w_full_ext  = {{PAD_W{1'b0}}, fifo_full};
  assign w_empty_ext = {{PAD_W{1'b0}}, fifo_empty};
  assign w_srst_ext  = {{PAD_W{1'b0}}, soft_reset};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_sel_q, dest_sel_d;
  logic              w_f, w_e, w_sr, w_addr_ok;

  assign w_f       = w_full_ext[dest_sel_q];
  assign w_e       = w_empty_ext[dest_sel_q];
  assign w_sr      = w_srst_ext[dest_sel_q];
  assign w_addr_ok = (data_in != INVALID_ADDR);
  assign dest_sel  = dest_sel_q;

  always_comb begin
    state_d    = state_q;
    dest_sel_d = dest_sel_q;
    if (state_q != DECODE_ADDRESS && w_sr) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_vld && w_addr_ok) begin
            dest_sel_d = data_in;
            state_d    = w_empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: if (w_e) state_d = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (w_f)           state_d = FIFO_FULL_STATE;
          else if (!pkt_vld) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: if (!w_f) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = w_f ? FIFO_FULL_STATE : DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are decoded from the next state so they align with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= DECODE_ADDRESS;
      dest_sel_q    <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      dest_sel_q    <= dest_sel_d;
      detect_add    <= (state_d == DECODE_ADDRESS);
      lfd_state     <= (state_d == LOAD_FIRST_DATA);
      ld_state      <= (state_d == LOAD_DATA);
      laf_state     <= (state_d == LOAD_AFTER_FULL);
      full_state    <= (state_d == FIFO_FULL_STATE);
      write_enb_reg <= (state_d inside {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY});
      rst_int_reg   <= (state_d == CHECK_PARITY_ERROR);
      busy          <= !(state_d inside {DECODE_ADDRESS, LOAD_DATA});
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_ctrl.sv
`default_nettype none
// ==== tb_router_fsm_ctrl : scoreboard bench for router_fsm_ctrl (rev 1.0) ====
module tb_router_fsm_ctrl;

  logic       clock = 1'b0;
  logic       reset, pkt_vld, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full, fifo_empty, soft_reset;
  logic [1:0] dest_sel;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  router_fsm_ctrl dut (
    .clock(clock), .reset(reset), .pkt_vld(pkt_vld), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .dest_sel(dest_sel), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] outs;
    logic [1:0] dest;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_st     = 0;
  logic [1:0] m_dest   = 2'd0;
  int         wr_cnt, busy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy} per state
  function automatic logic [7:0] outs_of(input int st);
    case (st)
      0:       return 8'b1000_0000;
      1:       return 8'b0000_0001;
      2:       return 8'b0100_0001;
      3:       return 8'b0010_0100;
      4:       return 8'b0000_1001;
      5:       return 8'b0001_0101;
      6:       return 8'b0000_0101;
      default: return 8'b0000_0011;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      m_st   = 0;
      m_dest = 2'd0;
    end else if (m_st != 0 && soft_reset[m_dest]) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: if (pkt_vld && data_in != 2'd3) begin
             m_st   = fifo_empty[data_in] ? 2 : 1;
             m_dest = data_in;
           end
        1: if (fifo_empty[m_dest]) m_st = 2;
        2: m_st = 3;
        3: if (fifo_full[m_dest]) m_st = 4; else if (!pkt_vld) m_st = 6;
        4: if (!fifo_full[m_dest]) m_st = 5;
        5: m_st = parity_done ? 0 : (low_pkt_valid ? 6 : 3);
        6: m_st = 7;
        default: m_st = fifo_full[m_dest] ? 4 : 0;
      endcase
    end
  endtask

  task automatic step(input string tag);
    exp_t       e;
    logic [7:0] o;
    model_step();
    e.outs = outs_of(m_st);
    e.dest = m_dest;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    o = {detect_add, lfd_state, ld_state, laf_state, full_state,
         write_enb_reg, rst_int_reg, busy};
    check_eq({tag, "_outs"}, 32'(o), 32'(e.outs));
    check_eq({tag, "_dest"}, 32'(dest_sel), 32'(e.dest));
    if (write_enb_reg) wr_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    pkt_vld = v;
    data_in = d;
  endtask

  initial begin
    reset = 1'b1; pkt_vld = 1'b0; data_in = 2'd0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
    wr_cnt = 0; busy_cnt = 0;
    #2;
    step("rst");
    reset = 1'b0;
    step("idle");
    check_eq("rst_detect", 32'(detect_add), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dest", 32'(dest_sel), 32'd0);

    // Normal packet to port 1: header, 4 payload, then pkt_vld drops
    wr_cnt = 0;
    drive(1'b1, 2'd1); step("t1_hdr");
    check_eq("t1_lfd", 32'(lfd_state), 32'd1);
    for (int i = 0; i < 4; i++) step("t1_pay");
    drive(1'b0, 2'd0);
    step("t1_lp"); step("t1_cpe"); step("t1_dec");
    check_eq("t1_wr_cnt", 32'(wr_cnt), 32'd5);
    check_eq("t1_dest_fix", 32'(dest_sel), 32'd1);

    // Port 2 not empty for 6 cycles
    fifo_empty = 3'b011; busy_cnt = 0;
    drive(1'b1, 2'd2); step("t3_hdr");
    for (int i = 0; i < 5; i++) step("t3_wait");
    check_eq("t3_busy_cnt", 32'(busy_cnt), 32'd6);
    fifo_empty = 3'b111; step("t3_lfd");
    check_eq("t3_lfd_now", 32'(lfd_state), 32'd1);
    step("t3_ld");
    drive(1'b0, 2'd0);
    step("t3_lp"); step("t3_cpe"); step("t3_dec");

    // Invalid address 3 is dropped
    wr_cnt = 0;
    drive(1'b1, 2'd3);
    for (int i = 0; i < 3; i++) step("t5_inv");
    check_eq("t5_dest_hold", 32'(dest_sel), 32'd2);
    check_eq("t5_no_write", 32'(wr_cnt), 32'd0);
    drive(1'b0, 2'd0); step("t5_idle");

    // FIFO full stall on port 0, then low_pkt_valid exit
    drive(1'b1, 2'd0); step("t4_hdr"); step("t4_ld");
    fifo_full = 3'b001; step("t4_full");
    check_eq("t4_full_state", 32'(full_state), 32'd1);
    check_eq("t4_full_busy", 32'(busy), 32'd1);
    step("t4_full2");
    fifo_full = 3'b000; step("t4_laf");
    check_eq("t4_laf_state", 32'(laf_state), 32'd1);
    low_pkt_valid = 1'b1; drive(1'b0, 2'd0); step("t4_lp");
    check_eq("t4_lp_wr", 32'(write_enb_reg), 32'd1);
    low_pkt_valid = 1'b0;
    step("t4_cpe"); step("t4_dec");

    // Soft reset in LOAD_DATA
    drive(1'b1, 2'd1); step("t6_hdr"); step("t6_ld");
    soft_reset = 3'b010; step("t6_sr");
    check_eq("t6_sr_detect", 32'(detect_add), 32'd1);
    check_eq("t6_sr_dest", 32'(dest_sel), 32'd1);
    soft_reset = 3'b000; drive(1'b0, 2'd0); step("t6_idle");

    // Full stall with parity_done exit, then hard reset from FIFO_FULL_STATE
    drive(1'b1, 2'd2); step("t7_hdr"); step("t7_ld");
    fifo_full = 3'b100; step("t7_full");
    fifo_full = 3'b000; step("t7_laf");
    parity_done = 1'b1; step("t7_pd");
    check_eq("t7_pd_detect", 32'(detect_add), 32'd1);
    parity_done = 1'b0;
    step("t7_hdr2"); step("t7_ld2");
    fifo_full = 3'b100; step("t7_full2");
    reset = 1'b1; step("t7_rst");
    check_eq("t7_rst_dest", 32'(dest_sel), 32'd0);
    check_eq("t7_rst_detect", 32'(detect_add), 32'd1);
    reset = 1'b0; fifo_full = 3'b000; drive(1'b0, 2'd0); step("t7_idle");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 59) == 0);
      pkt_vld       = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      fifo_empty    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
      soft_reset    = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000;
      parity_done   = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_fsm_ctrl.md
Name: router_fsm_ctrl

Overview:
- Input-side sequencing controller for the 1x3 router.
- Watches the source port (data_in, pkt_vld) and the per-destination FIFO status, then steps each packet through address decode, header load, payload load, FIFO-full stall and parity check.
- Drives the register-block and synchronizer enables, and drives busy back to the source driver.
- Sits between the source interface, the router register block and the three output FIFOs.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs.
- ADDR_W, 2, width of the header address field data_in[ADDR_W-1:0].

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- pkt_vld  input  1  source packet-valid strobe.
- data_in  input  ADDR_W  header address bits (data_in[1:0] of the source byte).
- fifo_full  input  NUM_PORTS  per-destination FIFO full flags.
- fifo_empty  input  NUM_PORTS  per-destination FIFO empty flags.
- soft_reset  input  NUM_PORTS  per-destination read-timeout soft reset.
- parity_done  input  1  register block has captured the parity byte.
- low_pkt_valid  input  1  register block: pkt_vld fell while a byte was held.
- dest_sel  output  ADDR_W  latched destination address.
- detect_add  output  1  header byte is being decoded.
- lfd_state  output  1  load first (header) byte.
- ld_state  output  1  load payload byte.
- laf_state  output  1  load the byte held during the full stall.
- full_state  output  1  stalled on destination full.
- write_enb_reg  output  1  FIFO write enable.
- rst_int_reg  output  1  clear the internal parity-error flag.
- busy  output  1  source must hold data_in and pkt_vld.

Behaviour:
- Reset: state returns to DECODE_ADDRESS and dest_sel clears to 0. All outputs then take their DECODE_ADDRESS values: detect_add=1, every other output 0.
- Output timing: all state-decoded outputs are Moore, registered through the state flops, with no combinational path from inputs.
- Address latch: dest_sel loads data_in only in DECODE_ADDRESS, when pkt_vld=1 and data_in < NUM_PORTS. Otherwise dest_sel holds.
- Selected-flag shorthand: F = fifo_full[dest_sel], E = fifo_empty[dest_sel], SR = soft_reset[dest_sel].
- DECODE_ADDRESS (detect_add=1, busy=0):
  - pkt_vld=1 and data_in valid: go to LOAD_FIRST_DATA if fifo_empty[data_in], else WAIT_TILL_EMPTY. This decision uses the live data_in, not dest_sel.
  - data_in = 3 (invalid): stay; the packet is dropped and no write occurs.
- WAIT_TILL_EMPTY (busy=1): go to LOAD_FIRST_DATA when E=1.
- LOAD_FIRST_DATA (lfd_state=1, busy=1): unconditionally go to LOAD_DATA.
- LOAD_DATA (ld_state=1, write_enb_reg=1, busy=0):
  - F=1: go to FIFO_FULL_STATE.
  - else pkt_vld=0: go to LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE (full_state=1, busy=1): go to LOAD_AFTER_FULL when F=0.
- LOAD_AFTER_FULL (laf_state=1, write_enb_reg=1, busy=1):
  - parity_done=1: go to DECODE_ADDRESS.
  - else low_pkt_valid=1: go to LOAD_PARITY.
  - else go to LOAD_DATA.
- LOAD_PARITY (write_enb_reg=1, busy=1): unconditionally go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR (rst_int_reg=1, busy=1): go to FIFO_FULL_STATE if F=1, else DECODE_ADDRESS.
- Soft reset: SR=1 in any state except DECODE_ADDRESS forces DECODE_ADDRESS next cycle. It has priority over every other transition, and dest_sel holds its value.
- Priority and stability:
  - reset > SR > the transition rules above.
  - Exactly one state-output strobe (detect_add, lfd_state, ld_state, laf_state, full_state) is high per cycle, except in WAIT_TILL_EMPTY, LOAD_PARITY and CHECK_PARITY_ERROR, where none is.
  - No X propagation from unused fifo_* bits.
- Reset mid-packet: returns to DECODE_ADDRESS on the next posedge regardless of state. Any partial packet is abandoned, and the controller does not resume it.
- Latency: header accepted in DECODE_ADDRESS cycle N; lfd_state=1 at N+1; first payload write at N+2.

Decomposition:
- Package router_pkg holds:
  - state enum state_t, 3-bit, values DECODE_ADDRESS=0 through CHECK_PARITY_ERROR=7, in the order listed above;
  - localparams NUM_PORTS and ADDR_W;
  - the invalid-address constant.
- No sub-module. The next-state logic, output decode and address latch fit one module.
- Bind an SVA checker for the one-hot strobe rule.

Test Plan:
- Reset then idle → detect_add=1, busy=0, dest_sel=0, all other outputs 0.
- Header data_in=2'b01, fifo_empty=3'b111, 4 payload bytes, then pkt_vld drops:
  - states run DECODE_ADDRESS → LOAD_FIRST_DATA → LOAD_DATA ×4 → LOAD_PARITY → CHECK_PARITY_ERROR → DECODE_ADDRESS;
  - dest_sel=1;
  - write_enb_reg=1 for 5 cycles (4 payload in LOAD_DATA plus 1 in LOAD_PARITY).
- Header data_in=2'b10 with fifo_empty[2]=0 for 6 cycles → WAIT_TILL_EMPTY with busy=1 for those 6 cycles; LOAD_FIRST_DATA the cycle after fifo_empty[2] rises.
- fifo_full[0] rises during LOAD_DATA to port 0:
  - next state is FIFO_FULL_STATE with busy=1;
  - fifo_full[0] falls → LOAD_AFTER_FULL;
  - with low_pkt_valid=1 → LOAD_PARITY.
- Header data_in=2'b11 with pkt_vld=1 → remains in DECODE_ADDRESS, dest_sel unchanged, no write_enb_reg.
- soft_reset[dest_sel] pulse in LOAD_DATA → DECODE_ADDRESS next cycle. A separate run with reset asserted in FIFO_FULL_STATE → DECODE_ADDRESS, dest_sel=0.
